// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl
//   Sequencer that sits between decode and the fetch redirect port. It accepts one
//   branch or jump op at a time from decode and drives the operand and condition
//   inputs of an external comparator. It then resolves the branch direction and
//   computes the target PC. When the resolved direction disagrees with the static
//   prediction, it issues a redirect to fetch.
//
//   Optional build macro: BRANCH_PERF_CNT_EN
//     Adds the 32-bit counters perf_branches and perf_mispredicts.
//
//   Ports
//     clk, rst_n        clock; synchronous active-low reset
//     op_*              op handshake and fields from decode (op_ready is an output)
//     cmp_rs1/rs2/ctrl  operands and condition for the comparator
//     cmp_result        comparator outcome, combinational in cmp_*
//     redir_*           mispredict redirect handshake toward fetch
//     link_pc           op_pc + 4, valid with done
//     done/taken/illegal  retire pulse and the resolved status of the op
//     flush             kills the in-flight op and returns the block to IDLE
//     perf_branches/perf_mispredicts  present only with BRANCH_PERF_CNT_EN
//
//   state | meaning
//   IDLE  | waiting for an op from decode
//   EVAL  | comparator is driven from the latched op; resolve direction and target
//   REDIR | mispredict; hold the redirect until fetch accepts it
module branch_seq_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] op_pc,
  input  logic [XLEN-1:0] op_imm,
  input  logic [2:0]      op_funct3,
  input  logic            op_is_jal,
  input  logic            op_is_jalr,
  input  logic [XLEN-1:0] op_rs1,
  input  logic [XLEN-1:0] op_rs2,
  input  logic            op_pred_taken,
  output logic [XLEN-1:0] cmp_rs1,
  output logic [XLEN-1:0] cmp_rs2,
  output logic [2:0]      cmp_ctrl,
  input  logic            cmp_result,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] link_pc,
  output logic            done,
  output logic            taken,
  output logic            illegal,
  input  logic            flush
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIR} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic            jal_q;
  logic            jalr_q;
  logic            pred_q;
  logic            done_q;
  logic            taken_q;
  logic            illegal_q;
  logic [XLEN-1:0] link_q;
  logic            pend_taken;
  logic            pend_illegal;
  logic [XLEN-1:0] pend_link;

  logic            is_jump;
  logic            ev_illegal;
  logic            ev_taken;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mispredict;
  logic            redir_hs;

  // Resolution of the op that is currently latched. It is only consumed in EVAL.
  assign is_jump    = jal_q | jalr_q;
  assign ev_illegal = !is_jump && (cmp_ctrl == 3'b010 || cmp_ctrl == 3'b011);
  assign ev_taken   = is_jump | (!ev_illegal & cmp_result);
  assign seq_pc     = pc_q + XLEN'(4);
  // cmp_rs1 holds the latched rs1, which serves as the jalr base.
  assign target_sum = (jalr_q ? cmp_rs1 : pc_q) + imm_q;
  assign target     = jalr_q ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign next_pc    = ev_taken ? target : seq_pc;
  assign mispredict = ev_taken != pred_q;

  // The redirect retires in the same cycle that fetch accepts it. On that cycle
  // the pending status is shown directly, so the held outputs do not change
  // before done is asserted.
  assign redir_hs = (state == REDIR) && redir_ready && !flush;
  assign done     = done_q | redir_hs;
  assign taken    = redir_hs ? pend_taken   : taken_q;
  assign illegal  = redir_hs ? pend_illegal : illegal_q;
  assign link_pc  = redir_hs ? pend_link    : link_q;

  // No op is accepted during the retire cycle itself. The next op can be accepted
  // on the following cycle.
  assign op_ready = (state == IDLE) && !flush && !done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc_q         <= '0;
      imm_q        <= '0;
      jal_q        <= 1'b0;
      jalr_q       <= 1'b0;
      pred_q       <= 1'b0;
      cmp_rs1      <= '0;
      cmp_rs2      <= '0;
      cmp_ctrl     <= 3'b000;
      redir_valid  <= 1'b0;
      redir_pc     <= RESET_PC;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      link_q       <= '0;
      pend_taken   <= 1'b0;
      pend_illegal <= 1'b0;
      pend_link    <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        redir_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (op_valid && op_ready) begin
              pc_q     <= op_pc;
              imm_q    <= op_imm;
              jal_q    <= op_is_jal;
              jalr_q   <= op_is_jalr;
              pred_q   <= op_pred_taken;
              cmp_rs1  <= op_rs1;
              cmp_rs2  <= op_rs2;
              cmp_ctrl <= op_funct3;
              state    <= EVAL;
            end
          end
          EVAL: begin
            if (mispredict) begin
              redir_pc     <= next_pc;
              redir_valid  <= 1'b1;
              pend_taken   <= ev_taken;
              pend_illegal <= ev_illegal;
              pend_link    <= seq_pc;
              state        <= REDIR;
            end else begin
              taken_q   <= ev_taken;
              illegal_q <= ev_illegal;
              link_q    <= seq_pc;
              done_q    <= 1'b1;
              state     <= IDLE;
            end
          end
          REDIR: begin
            if (redir_ready) begin
              taken_q     <= pend_taken;
              illegal_q   <= pend_illegal;
              link_q      <= pend_link;
              redir_valid <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (done) begin
      perf_branches <= perf_branches + 32'd1;
      if (redir_hs) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Sequencer for the RV32 branch comparator. It takes one branch/jump op per handshake from decode and drives the comparator's operand and ctrl inputs. It registers the comparator's taken/not-taken result, computes the target PC, checks it against the static prediction, and issues a redirect/flush request to fetch. Ops are single-outstanding; the block sits between decode and the fetch redirect port.

Parameters:
XLEN, 32, operand and PC width
RESET_PC, 32'h0000_0000, value of the last_target register after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
op_valid  in  1  decode presents a branch/jump op
op_ready  out  1  block can accept an op
op_pc  in  XLEN  PC of the op
op_imm  in  XLEN  sign-extended immediate
op_funct3  in  3  branch condition; same encoding as the comparator ctrl
op_is_jal  in  1  unconditional PC-relative jump
op_is_jalr  in  1  unconditional register jump
op_rs1  in  XLEN  rs1 value
op_rs2  in  XLEN  rs2 value
op_pred_taken  in  1  static prediction taken by fetch
cmp_rs1  out  XLEN  operand to comparator
cmp_rs2  out  XLEN  operand to comparator
cmp_ctrl  out  3  condition to comparator
cmp_result  in  1  comparator outcome, combinational in cmp_* outputs
redir_valid  out  1  mispredict redirect request
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  corrected fetch PC
link_pc  out  XLEN  op_pc+4, valid with done
done  out  1  one-cycle pulse: op retired from this block
taken  out  1  resolved direction, valid with done
illegal  out  1  funct3 is 010 or 011 on a conditional op, valid with done
flush  in  1  kill in-flight op; return to IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; op_ready=1; redir_valid=0; done=0; taken=0; illegal=0; cmp_* outputs=0; redir_pc=RESET_PC; link_pc=0.
- FSM states: IDLE, EVAL, REDIR.
- IDLE: op_ready=1. On op_valid&&op_ready, latch all op_* fields and go to EVAL. op_ready=0 in every state other than IDLE.
- EVAL (exactly 1 cycle): cmp_rs1/cmp_rs2/cmp_ctrl are driven from the latched fields. Resolved direction:
  - jal/jalr: taken=1, comparator ignored.
  - funct3 010/011: taken=0, illegal=1.
  - otherwise: taken=cmp_result.
- EVAL target:
  - jal and branch: pc+imm.
  - jalr: (rs1+imm) with bit0 cleared.
  - Addition wraps modulo 2^XLEN.
- EVAL next-PC: taken?target:pc+4. Mispredict = taken != pred_taken. jal/jalr always use pred_taken as given.
  - No mispredict: pulse done, go to IDLE.
  - Mispredict: load redir_pc=next-PC, set redir_valid=1, go to REDIR.
- REDIR: hold redir_valid and redir_pc stable until redir_ready. On the handshake cycle, pulse done and go to IDLE; redir_valid drops the next cycle.
- Latency: op accepted at cycle N. done at N+2 when no mispredict; with mispredict, done on the redir_ready cycle (≥N+2). A new op can be accepted the cycle after done.
- cmp_* outputs hold the last latched values outside EVAL.
- flush: highest priority after reset. Forces IDLE next cycle, clears redir_valid, suppresses done. flush in IDLE with op_valid: the op is not accepted (op_ready=0 during flush).
- redir_ready while redir_valid=0 is ignored.
- taken, illegal and link_pc hold until the next done.

Optional Feature:
BRANCH_PERF_CNT_EN:
- Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0]. On each done, perf_branches increments, and perf_mispredicts increments if a redirect was issued. Both are 32-bit free-running counters that wrap at 2^32, cleared by rst_n, and not affected by flush.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> cmp_ctrl=000 in EVAL; redir_pc=0x120, redir_valid held 3 cycles with redir_ready low; done on handshake; taken=1.
- BLTU, rs1=0xFFFF_FFFF, rs2=1, pred=0 -> taken=0, no redirect, done at N+2, link_pc=pc+4.
- JALR, rs1=0x1001, imm=0x4, pred=1 -> target 0x1004 (bit0 cleared), no redirect, taken=1, comparator result ignored.
- funct3=010 -> illegal=1, taken=0; pred=1 forces redirect to pc+4.
- flush asserted in REDIR -> redir_valid=0 next cycle, no done, op_ready=1 the cycle after.
- Wrap: pc=0xFFFF_FFF0, imm=0x20, taken -> redir_pc=0x0000_0010. Back-to-back ops: second op accepted the cycle after the first done.
